// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the instruction sequencer slice.
//
// Contents:
//   SEQ_STEP_W / SEQ_XLEN : default step-counter and datapath widths.
//   OP_* : opcodes of the supported instruction classes.
//   seq_state_t : sequencer FSM state.
//   STEP0..STEP4 : one-hot step counter values.
//   is_legal() : true for opcodes the sequencer can execute.
package seq_pkg;

  localparam int SEQ_STEP_W = 5;
  localparam int SEQ_XLEN   = 32;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ERR
  } seq_state_t;

  localparam logic [SEQ_STEP_W-1:0] STEP0 = 5'b00001;
  localparam logic [SEQ_STEP_W-1:0] STEP1 = 5'b00010;
  localparam logic [SEQ_STEP_W-1:0] STEP2 = 5'b00100;
  localparam logic [SEQ_STEP_W-1:0] STEP3 = 5'b01000;
  localparam logic [SEQ_STEP_W-1:0] STEP4 = 5'b10000;

  // Only beq exists among branches, so any other funct3 is treated as illegal.
  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_IMM) || (opcode == OP_REG) || (opcode == OP_LUI) ||
           ((opcode == OP_BRANCH) && (funct3 == 3'b000));
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: fetch/datapath <-> sequencer bundle.
//
// Signals:
//   instr_valid / instr_ready / instruction : instruction handshake.
//   alu_flag : branch compare result from the ALU.
//   instruction_counter : one-hot current step (0 when idle).
//   imm, imm_EN : immediate value and its bus drive enable.
//   register_index, register_read_enable, register_write_enable : register file control.
//   alu_store_1, alu_store_2, alu_broadcast, alu_op : ALU control.
//   done, branch_taken, illegal : retirement/status pulses to the PC logic.
// Modports: slave = sequencer, master = fetch/datapath side.
interface instr_sequencer_if
  import seq_pkg::*;
#(
  parameter int STEP_W = SEQ_STEP_W,
  parameter int XLEN   = SEQ_XLEN
);

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction;
  logic              alu_flag;
  logic [STEP_W-1:0] instruction_counter;
  logic [XLEN-1:0]   imm;
  logic              imm_EN;
  logic [4:0]        register_index;
  logic              register_read_enable;
  logic              register_write_enable;
  logic              alu_store_1;
  logic              alu_store_2;
  logic              alu_broadcast;
  logic [3:0]        alu_op;
  logic              done;
  logic              branch_taken;
  logic              illegal;

  modport slave (
    input  instr_valid, instruction, alu_flag,
    output instr_ready, instruction_counter, imm, imm_EN, register_index,
           register_read_enable, register_write_enable, alu_store_1,
           alu_store_2, alu_broadcast, alu_op, done, branch_taken, illegal
  );

  modport master (
    output instr_valid, instruction, alu_flag,
    input  instr_ready, instruction_counter, imm, imm_EN, register_index,
           register_read_enable, register_write_enable, alu_store_1,
           alu_store_2, alu_broadcast, alu_op, done, branch_taken, illegal
  );

endinterface

// File: rtl/instr_imm_gen.sv
// instr_imm_gen: combinational immediate extraction by instruction class.
//
// Ports:
//   instruction (in, 32) : latched instruction word.
//   imm (out, XLEN) : I-type zero-extended [31:20], lui [31:12]<<12,
//                     beq sign-extended branch offset, 0 otherwise.
module instr_imm_gen
  import seq_pkg::*;
#(
  parameter int XLEN = SEQ_XLEN
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm
);

  logic [12:0] branch_off;

  // B-type offset is scattered across the word; bit 0 is always zero.
  assign branch_off = {instruction[31], instruction[7], instruction[30:25],
                       instruction[11:8], 1'b0};

  always_comb begin
    imm = '0;
    case (instruction[6:0])
      OP_IMM:    imm = XLEN'(instruction[31:20]);
      OP_LUI:    imm = XLEN'({instruction[31:12], 12'b0});
      OP_BRANCH: imm = XLEN'($signed(branch_off));
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for the single-bus datapath.
//
// Ports:
//   clk (in) : rising-edge clock.
//   resetn (in) : asynchronous active-low reset.
//   stall (in, only with SEQ_STALL_EN) : freezes the current step while high.
//   bus (instr_sequencer_if.slave) : handshake, datapath enables and status.
//
// Optional feature macro: SEQ_STALL_EN (adds the stall input). Without it
// steps advance every cycle.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int STEP_W = SEQ_STEP_W,
  parameter int XLEN   = SEQ_XLEN
) (
  input logic clk,
  input logic resetn,
`ifdef SEQ_STALL_EN
  input logic stall,
`endif
  instr_sequencer_if.slave bus
);

  seq_state_t        state;
  logic [31:0]       instr_q;
  logic [STEP_W-1:0] counter;
  logic [XLEN-1:0]   imm_raw;
  logic              hold;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  logic [4:0] idx;
  logic       rd_en, wr_raw, st1_raw, st2_raw, imm_en, bcast, done_raw, br_raw;
  logic [3:0] op;
  logic       done_q;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

`ifdef SEQ_STALL_EN
  assign hold = stall & (state == EXEC);
`else
  assign hold = 1'b0;
`endif

  instr_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction(instr_q),
    .imm        (imm_raw)
  );

  // Per-class step table. Only one of read/imm_en/broadcast is ever set in
  // a given step so the shared bus never has two drivers.
  always_comb begin
    idx      = '0;
    rd_en    = 1'b0;
    wr_raw   = 1'b0;
    st1_raw  = 1'b0;
    st2_raw  = 1'b0;
    imm_en   = 1'b0;
    bcast    = 1'b0;
    done_raw = 1'b0;
    br_raw   = 1'b0;
    op       = '0;
    if (state == EXEC) begin
      case (opcode)
        OP_IMM, OP_REG: begin
          op = {instr_q[30], funct3};
          if (counter[0]) begin
            idx = rs1; rd_en = 1'b1; st1_raw = 1'b1;
          end else if (counter[1]) begin
            st2_raw = 1'b1;
            if (opcode == OP_IMM) begin
              imm_en = 1'b1;
            end else begin
              idx = rs2; rd_en = 1'b1;
            end
          end else if (counter[2]) begin
            idx = rd; bcast = 1'b1; wr_raw = 1'b1; done_raw = 1'b1;
          end
        end
        OP_LUI: begin
          op = 4'b0000;
          if (counter[0]) begin
            idx = rd; imm_en = 1'b1; wr_raw = 1'b1;
          end else if (counter[1]) begin
            done_raw = 1'b1;
          end
        end
        OP_BRANCH: begin
          op = 4'b1000;
          if (counter[0]) begin
            idx = rs1; rd_en = 1'b1; st1_raw = 1'b1;
          end else if (counter[1]) begin
            idx = rs2; rd_en = 1'b1; st2_raw = 1'b1;
          end else if (counter[2]) begin
            done_raw = 1'b1; br_raw = bus.alu_flag;
          end
        end
        default: ;
      endcase
    end
  end

  assign done_q = done_raw & ~hold;

  // Writes to x0 are dropped; stall suppresses every side effect of the step.
  assign bus.register_write_enable = wr_raw & (rd != 5'd0) & ~hold;
  assign bus.alu_store_1           = st1_raw & ~hold;
  assign bus.alu_store_2           = st2_raw & ~hold;
  assign bus.done                  = done_q;
  assign bus.branch_taken          = br_raw & ~hold;
  assign bus.register_read_enable  = rd_en;
  assign bus.imm_EN                = imm_en;
  assign bus.alu_broadcast         = bcast;
  assign bus.register_index        = idx;
  assign bus.alu_op                = op;
  assign bus.imm                   = (state == EXEC) ? imm_raw : '0;
  assign bus.instruction_counter   = counter;
  assign bus.illegal               = (state == ERR);
  assign bus.instr_ready           = (state == IDLE) & resetn;

  // FSM: accept in IDLE, walk the one-hot counter in EXEC until done,
  // spend a single cycle in ERR for unsupported opcodes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      instr_q <= '0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instruction;
            if (is_legal(bus.instruction[6:0], bus.instruction[14:12])) begin
              state   <= EXEC;
              counter <= STEP_W'(STEP0);
            end else begin
              state <= ERR;
            end
          end
        end
        EXEC: begin
          if (!hold) begin
            if (done_q) begin
              state   <= IDLE;
              counter <= '0;
            end else begin
              counter <= counter << 1;
            end
          end
        end
        ERR: state <= IDLE;
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer.
// Expected per-cycle output records are queued when an instruction is
// offered and popped/compared each cycle the DUT runs it.
// Stall coverage is included when SEQ_STALL_EN is defined.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic stall = 1'b0;

  int checks = 0;
  int failures = 0;

  instr_sequencer_if #(.STEP_W(5), .XLEN(32)) bus ();

  instr_sequencer dut (
    .clk   (clk),
    .resetn(resetn),
`ifdef SEQ_STALL_EN
    .stall (stall),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control vector bit positions, MSB first.
  localparam logic [9:0] C_READY = 10'b1000000000;
  localparam logic [9:0] C_IMMEN = 10'b0100000000;
  localparam logic [9:0] C_RD    = 10'b0010000000;
  localparam logic [9:0] C_WR    = 10'b0001000000;
  localparam logic [9:0] C_ST1   = 10'b0000100000;
  localparam logic [9:0] C_ST2   = 10'b0000010000;
  localparam logic [9:0] C_BC    = 10'b0000001000;
  localparam logic [9:0] C_DONE  = 10'b0000000100;
  localparam logic [9:0] C_BR    = 10'b0000000010;
  localparam logic [9:0] C_ILL   = 10'b0000000001;

  typedef struct {
    logic [4:0]  cnt;
    logic [4:0]  idx;
    logic [9:0]  ctl;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        stl;
  } exp_t;

  exp_t expQ[$];

  // Counts a comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obsCtl();
    return {bus.instr_ready, bus.imm_EN, bus.register_read_enable,
            bus.register_write_enable, bus.alu_store_1, bus.alu_store_2,
            bus.alu_broadcast, bus.done, bus.branch_taken, bus.illegal};
  endfunction

  function automatic void pushExp(input logic [4:0] cnt, input logic [4:0] idx,
                                  input logic [9:0] ctl, input logic [31:0] imm,
                                  input logic [3:0] op, input logic stl);
    exp_t e;
    e.cnt = cnt; e.idx = idx; e.ctl = ctl; e.imm = imm; e.op = op; e.stl = stl;
    expQ.push_back(e);
  endfunction

  // Reference behaviour: builds the expected cycle-by-cycle trace of one
  // instruction, ending with the idle cycle where ready returns.
  function automatic void buildTrace(input logic [31:0] w, input logic flag, input int stallN);
    logic [6:0]  opc = w[6:0];
    logic [4:0]  rdv = w[11:7];
    logic [4:0]  r1 = w[19:15];
    logic [4:0]  r2 = w[24:20];
    logic [2:0]  f3 = w[14:12];
    logic [9:0]  wrb = (rdv != 0) ? C_WR : 10'b0;
    logic [31:0] iv;
    logic [3:0]  aop;
    aop = {w[30], f3};
    iv = 32'h0;
    case (opc)
      7'b0010011: iv = {20'h0, w[31:20]};
      7'b0110111: begin iv = {w[31:12], 12'h000}; aop = 4'h0; end
      7'b1100011: begin iv = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; aop = 4'h8; end
      default: iv = 32'h0;
    endcase
    if (opc == 7'b0010011) begin
      pushExp(5'b00001, r1, C_RD | C_ST1, iv, aop, 1'b0);
      pushExp(5'b00010, 5'd0, C_IMMEN | C_ST2, iv, aop, 1'b0);
      pushExp(5'b00100, rdv, C_BC | wrb | C_DONE, iv, aop, 1'b0);
    end else if (opc == 7'b0110011) begin
      pushExp(5'b00001, r1, C_RD | C_ST1, iv, aop, 1'b0);
      for (int k = 0; k < stallN; k++) pushExp(5'b00010, r2, C_RD, iv, aop, 1'b1);
      pushExp(5'b00010, r2, C_RD | C_ST2, iv, aop, 1'b0);
      pushExp(5'b00100, rdv, C_BC | wrb | C_DONE, iv, aop, 1'b0);
    end else if (opc == 7'b0110111) begin
      pushExp(5'b00001, rdv, C_IMMEN | wrb, iv, aop, 1'b0);
      pushExp(5'b00010, 5'd0, C_DONE, iv, aop, 1'b0);
    end else if (opc == 7'b1100011 && f3 == 3'b000) begin
      pushExp(5'b00001, r1, C_RD | C_ST1, iv, aop, 1'b0);
      pushExp(5'b00010, r2, C_RD | C_ST2, iv, aop, 1'b0);
      pushExp(5'b00100, 5'd0, C_DONE | (flag ? C_BR : 10'b0), iv, aop, 1'b0);
    end else begin
      pushExp(5'b00000, 5'd0, C_ILL, 32'h0, 4'h0, 1'b0);
    end
    pushExp(5'b00000, 5'd0, C_READY, 32'h0, 4'h0, 1'b0);
  endfunction

  task automatic waitReady(input string tag);
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({tag, " ready"}, {31'h0, bus.instr_ready}, 32'h1);
  endtask

  // Offers one instruction, queues its expected trace and compares the DUT
  // against it each cycle until the queue drains.
  task automatic applyStimulus(input string tag, input logic [31:0] w, input logic flag, input int stallN);
    exp_t e;
    int cyc = 0;
    waitReady(tag);
    bus.instr_valid = 1'b1;
    bus.instruction = w;
    bus.alu_flag = flag;
    buildTrace(w, flag, stallN);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      @(negedge clk);
      stall = e.stl;
      #1;
      checkOutput($sformatf("%s c%0d cnt", tag, cyc), {27'h0, bus.instruction_counter}, {27'h0, e.cnt});
      checkOutput($sformatf("%s c%0d idx", tag, cyc), {27'h0, bus.register_index}, {27'h0, e.idx});
      checkOutput($sformatf("%s c%0d ctl", tag, cyc), {22'h0, obsCtl()}, {22'h0, e.ctl});
      checkOutput($sformatf("%s c%0d imm", tag, cyc), bus.imm, e.imm);
      checkOutput($sformatf("%s c%0d op", tag, cyc), {28'h0, bus.alu_op}, {28'h0, e.op});
      cyc++;
    end
    stall = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " cnt"}, {27'h0, bus.instruction_counter}, 32'h0);
    checkOutput({tag, " ctl"}, {22'h0, obsCtl()}, 32'h0);
    checkOutput({tag, " idx"}, {27'h0, bus.register_index}, 32'h0);
    checkOutput({tag, " imm"}, bus.imm, 32'h0);
    checkOutput({tag, " op"}, {28'h0, bus.alu_op}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instruction = 32'h0;
    bus.alu_flag = 1'b0;
    resetn = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("post-reset ctl", {22'h0, obsCtl()}, {22'h0, C_READY});

    applyStimulus("addi x5,x1,7", 32'h00708293, 1'b0, 0);
    applyStimulus("add x3,x1,x2", 32'h002081B3, 1'b0, 0);
    applyStimulus("lui x4", 32'h12345237, 1'b0, 0);
    applyStimulus("beq taken", 32'h00208463, 1'b1, 0);
    applyStimulus("beq not taken", 32'h00208463, 1'b0, 0);
    applyStimulus("opcode 7F", 32'h0000007F, 1'b0, 0);
    applyStimulus("addi x0,x0,1", 32'h00100013, 1'b0, 0);
    applyStimulus("bne illegal", 32'h00209463, 1'b1, 0);
    applyStimulus("sub x7,x6,x5", 32'h405303B3, 1'b0, 0);
    applyStimulus("beq back", 32'hFE208EE3, 1'b1, 0);

    // Reset abandons an add during step1 without a done pulse.
    waitReady("rst-add");
    bus.instr_valid = 1'b1;
    bus.instruction = 32'h002081B3;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("rst-add step1 cnt", {27'h0, bus.instruction_counter}, 32'h2);
    resetn = 1'b0;
    #1;
    checkAllZero("mid-reset");
    @(negedge clk); #1;
    checkOutput("mid-reset done", {31'h0, bus.done}, 32'h0);
    resetn = 1'b1;
    #1;
    checkOutput("release ctl", {22'h0, obsCtl()}, {22'h0, C_READY});
    applyStimulus("addi after reset", 32'h00708293, 1'b0, 0);

`ifdef SEQ_STALL_EN
    applyStimulus("add stalled", 32'h002081B3, 1'b0, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the single-bus datapath (register file, two-operand ALU latches, immediate driver). Accepts one 32-bit instruction via valid/ready handshake, decodes the class (R-type, I-type ALU, lui, branch), and steps a one-hot step counter. Drives the register, ALU and immediate enables for each step, and reports retirement, taken branches and illegal opcodes to the fetch/PC logic.

Parameters:
STEP_W, 5, width of the one-hot step counter (max 5 steps per instruction)
XLEN, 32, datapath/immediate width

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
instr_valid  in  1  fetch offers an instruction
instr_ready  out  1  sequencer can accept (IDLE only)
instruction  in  32  instruction word, sampled on accept
alu_flag  in  1  ALU compare result for branches (1 = condition true)
instruction_counter  out  STEP_W  one-hot current step, 0 when idle
imm  out  XLEN  decoded immediate (I: zero-extended [31:20]; U: [31:12]<<12; B: sign-extended branch offset)
imm_EN  out  1  drive imm onto the bus
register_index  out  5  register file address
register_read_enable  out  1  register read onto bus
register_write_enable  out  1  register write from bus
alu_store_1, alu_store_2  out  1 each  latch bus into ALU operand A / B
alu_broadcast  out  1  ALU result onto bus
alu_op  out  4  {funct7[5], funct3}; forced to 4'b0000 (add) for lui, 4'b1000 (sub/compare) for branch
done  out  1  one-cycle retire pulse
branch_taken  out  1  one-cycle pulse with done; PC loads pc + imm
illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (asynchronous, resetn low): state IDLE; instruction register = 0; all outputs 0, except instr_ready = 1 once resetn is released. A reset mid-instruction abandons it without emitting done.
- States: IDLE, EXEC, ERR.
- IDLE: instr_ready = 1. On instr_valid & instr_ready, latch the instruction. For a legal opcode go to EXEC with instruction_counter = 00001 on the next cycle. Otherwise go to ERR.
- EXEC: instruction_counter shifts left one bit per cycle. Control outputs are combinational from the latched instruction and the counter. instr_ready = 0.
- I-type (0010011):
  - step0: register_index = rs1, read, alu_store_1
  - step1: imm_EN, alu_store_2
  - step2: alu_broadcast, register_index = rd, write, done
- R-type (0110011):
  - step0: rs1 to alu_store_1
  - step1: rs2 to alu_store_2
  - step2: broadcast, write rd, done
- lui (0110111):
  - step0: imm_EN, write rd
  - step1: done
- branch (1100011, funct3 000 beq only):
  - step0: rs1 to alu_store_1
  - step1: rs2 to alu_store_2
  - step2: done; branch_taken = alu_flag
- Retirement: when done is high, the next state is IDLE and the counter clears to 0. Accept-to-done latency is 3 cycles (lui 2); the next accept can occur 1 cycle after done.
- rd == 0: register_write_enable is suppressed (held 0); all other signals are unchanged.
- ERR: illegal = 1 for one cycle, no register or ALU enables, then return to IDLE. Also covers branch with funct3 != 000.
- Only one of register_read_enable, imm_EN, alu_broadcast is high in any cycle (single-bus rule).
- instr_valid while busy is ignored; fetch must hold instr_valid until ready.

Optional Feature:
SEQ_STALL_EN: adds input `stall` (1 bit).
- With the macro: while stall = 1 in EXEC, the counter and state hold, and all write/store/done/branch_taken outputs are gated to 0 (reads may stay asserted). The step completes once stall drops.
- Without the macro: the port is absent and steps always advance each cycle.

Decomposition:
- Shared package seq_pkg holds:
  - opcode constants OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_LUI = 7'b0110111, OP_BRANCH = 7'b1100011
  - state enum seq_state_t {IDLE, EXEC, ERR}
  - step constants STEP0..STEP4
- One sub-module, instr_imm_gen: combinational immediate extraction per class, instantiated once.

Test Plan:
- addi x5,x1,7 (0x00708293) -> counter 00001/00010/00100:
  - step0: index 1, read, store_1
  - step1: imm = 7, imm_EN, store_2
  - step2: index 5, write, broadcast, done; instr_ready back 1 cycle later
- add x3,x1,x2 (0x002081B3) -> reads index 1 then 2, write index 3 at step2, alu_op = 0000, done at cycle 3.
- lui x4,0x12345 (0x12345237) -> step0 imm = 0x12345000, imm_EN, write index 4; done at step1; no reads.
- beq x1,x2,+8 (0x00208463):
  - alu_flag = 1 -> branch_taken and done at step2, imm = 8, no register write
  - repeat with alu_flag = 0 -> done, branch_taken = 0
- Opcode 0x7F, then addi x0,x0,1 -> illegal pulses 1 cycle, no enables; addi completes with register_write_enable never high.
- resetn low during step1 of add -> all outputs 0 immediately, no done; after release instr_ready = 1 and the next addi executes normally. With SEQ_STALL_EN, stall during step1 for 3 cycles -> counter holds 00010 and store_2 stays 0 until release.
